// File: rtl/hazard_if.sv
// Signal bundle between the pipeline (master) and hazard_unit_mc (slave).
// StallCount/FlushCount and STAT_WIDTH exist only when HAZARD_STATS_EN is defined.
interface hazard_if #(
  parameter int NSRC = 3
`ifdef HAZARD_STATS_EN
  , parameter int STAT_WIDTH = 16
`endif
);
  logic [NSRC-1:0]   Match_E_M;
  logic [NSRC-1:0]   Match_E_W;
  logic              Match_12D_E;
  logic              RegWriteM;
  logic              RegWriteW;
  logic              MemtoRegE;
  logic              BranchTakenE;
  logic              PCWrPendingF;
  logic              PCSrcW;
  logic              MultiCycleE;
  logic [2*NSRC-1:0] ForwardE;
  logic              StallF;
  logic              StallD;
  logic              StallE;
  logic              FlushD;
  logic              FlushE;
  logic              FlushM;
  logic              BusyE;
`ifdef HAZARD_STATS_EN
  logic [STAT_WIDTH-1:0] StallCount;
  logic [STAT_WIDTH-1:0] FlushCount;

  modport master (
    output Match_E_M, Match_E_W, Match_12D_E, RegWriteM, RegWriteW, MemtoRegE,
           BranchTakenE, PCWrPendingF, PCSrcW, MultiCycleE,
    input  ForwardE, StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE,
           StallCount, FlushCount
  );
  modport slave (
    input  Match_E_M, Match_E_W, Match_12D_E, RegWriteM, RegWriteW, MemtoRegE,
           BranchTakenE, PCWrPendingF, PCSrcW, MultiCycleE,
    output ForwardE, StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE,
           StallCount, FlushCount
  );
`else
  modport master (
    output Match_E_M, Match_E_W, Match_12D_E, RegWriteM, RegWriteW, MemtoRegE,
           BranchTakenE, PCWrPendingF, PCSrcW, MultiCycleE,
    input  ForwardE, StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE
  );
  modport slave (
    input  Match_E_M, Match_E_W, Match_12D_E, RegWriteM, RegWriteW, MemtoRegE,
           BranchTakenE, PCWrPendingF, PCSrcW, MultiCycleE,
    output ForwardE, StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE
  );
`endif
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage core: NSRC-way forwarding, load-use/branch/PC-write
// hazards and a multi-cycle execute hold. Optional counters via HAZARD_STATS_EN.
module hazard_unit_mc #(
  parameter int NSRC        = 3,
  parameter int MUL_LATENCY = 4,
  parameter int CNT_WIDTH   = 4
`ifdef HAZARD_STATS_EN
  , parameter int STAT_WIDTH = 16
`endif
) (
  input logic     clk,
  input logic     reset,
  hazard_if.slave hz
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // First BUSY cycle is already the op's second cycle in E, hence the -2.
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD =
    CNT_WIDTH'((MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0);

  state_t                state_r;
  state_t                state_nxt_s;
  logic [CNT_WIDTH-1:0]  cnt_r;
  logic [CNT_WIDTH-1:0]  cnt_nxt_s;
  logic                  mc_stall_s;
  logic                  ldr_stall_s;
  logic [2*NSRC-1:0]     fwd_s;

  // Per-source forwarding select, M beats W
  always_comb begin
    fwd_s = {(2*NSRC){1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      if (hz.Match_E_M[i] && hz.RegWriteM) begin
        fwd_s[2*i +: 2] = 2'b10;
      end else if (hz.Match_E_W[i] && hz.RegWriteW) begin
        fwd_s[2*i +: 2] = 2'b01;
      end else begin
        fwd_s[2*i +: 2] = 2'b00;
      end
    end
  end

  // Multi-cycle controller next-state and stall decision
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    mc_stall_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (hz.MultiCycleE && (MUL_LATENCY > 1)) begin
          mc_stall_s  = 1'b1;
          state_nxt_s = BUSY;
          cnt_nxt_s   = CNT_LOAD;
        end else begin
          mc_stall_s  = 1'b0;
        end
      end
      BUSY: begin
        if (!hz.MultiCycleE) begin
          // op squashed while held
          state_nxt_s = IDLE;
          cnt_nxt_s   = {CNT_WIDTH{1'b0}};
        end else if (cnt_r != {CNT_WIDTH{1'b0}}) begin
          mc_stall_s  = 1'b1;
          cnt_nxt_s   = cnt_r - CNT_WIDTH'(1);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_WIDTH{1'b0}};
      end
    endcase
  end

  // Controller state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign ldr_stall_s  = hz.Match_12D_E & hz.MemtoRegE;
  assign hz.ForwardE  = fwd_s;
  assign hz.StallF    = ldr_stall_s | hz.PCWrPendingF | mc_stall_s;
  assign hz.StallD    = ldr_stall_s | mc_stall_s;
  assign hz.StallE    = mc_stall_s;
  assign hz.FlushM    = mc_stall_s;
  assign hz.FlushD    = hz.PCWrPendingF | hz.PCSrcW | hz.BranchTakenE;
  // A held E instruction must never be cleared
  assign hz.FlushE    = (ldr_stall_s | hz.BranchTakenE) & ~mc_stall_s;
  assign hz.BusyE     = (state_r == BUSY);

`ifdef HAZARD_STATS_EN
  logic [STAT_WIDTH-1:0] stall_cnt_r;
  logic [STAT_WIDTH-1:0] flush_cnt_r;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + STAT_WIDTH'(1);
    end
  endfunction

  // Saturating stall/flush statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= {STAT_WIDTH{1'b0}};
      flush_cnt_r <= {STAT_WIDTH{1'b0}};
    end else begin
      if (hz.StallF) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
      if (hz.FlushD | hz.FlushE) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end
    end
  end

  assign hz.StallCount = stall_cnt_r;
  assign hz.FlushCount = flush_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Randomised + directed bench for hazard_unit_mc against an age-based reference model.
module tb_hazard_unit_mc;
  localparam int NSRC        = 3;
  localparam int MUL_LATENCY = 4;
  localparam int CNT_WIDTH   = 4;
`ifdef HAZARD_STATS_EN
  localparam int STAT_WIDTH  = 2;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_if #(.NSRC(NSRC)
`ifdef HAZARD_STATS_EN
    , .STAT_WIDTH(STAT_WIDTH)
`endif
  ) hz ();

  hazard_unit_mc #(.NSRC(NSRC), .MUL_LATENCY(MUL_LATENCY), .CNT_WIDTH(CNT_WIDTH)
`ifdef HAZARD_STATS_EN
    , .STAT_WIDTH(STAT_WIDTH)
`endif
  ) dut (.clk(clk), .reset(reset), .hz(hz));

  int checks = 0;
  int failures = 0;

  // Model: is an op already in flight, and how many cycles it has spent in E
  bit m_busy = 1'b0;
  int m_age  = 0;
  int m_stall_cnt = 0;
  int m_flush_cnt = 0;

  // Outputs captured at the last sampling point, for directed test-plan checks
  logic [2*NSRC-1:0] o_fwd;
  logic o_sf, o_sd, o_se, o_fd, o_fe, o_fm, o_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [NSRC-1:0] mem, input logic [NSRC-1:0] mew,
                       input logic m12, input logic rwm, input logic rww, input logic mtr,
                       input logic bt, input logic pcwp, input logic pcs, input logic mc);
    hz.Match_E_M = mem;  hz.Match_E_W = mew;  hz.Match_12D_E = m12;
    hz.RegWriteM = rwm;  hz.RegWriteW = rww;  hz.MemtoRegE = mtr;
    hz.BranchTakenE = bt; hz.PCWrPendingF = pcwp; hz.PCSrcW = pcs; hz.MultiCycleE = mc;
  endtask

  task automatic idle_inputs();
    drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock: sample outputs at negedge, compare with model, then advance model at posedge
  task automatic step(input string tag);
    int fwd, sel, age_now;
    bit ld, mcs, e_sf, e_fd, e_fe;
    @(negedge clk);
    fwd = 0;
    for (int i = 0; i < NSRC; i++) begin
      sel = (hz.Match_E_M[i] && hz.RegWriteM) ? 2 : ((hz.Match_E_W[i] && hz.RegWriteW) ? 1 : 0);
      fwd = fwd + sel * (4 ** i);
    end
    ld      = hz.Match_12D_E && hz.MemtoRegE;
    age_now = m_busy ? m_age + 1 : 0;
    mcs     = hz.MultiCycleE && (age_now < MUL_LATENCY - 1);
    e_sf    = ld || hz.PCWrPendingF || mcs;
    e_fd    = hz.PCWrPendingF || hz.PCSrcW || hz.BranchTakenE;
    e_fe    = (ld || hz.BranchTakenE) && !mcs;
    o_fwd = hz.ForwardE; o_sf = hz.StallF; o_sd = hz.StallD; o_se = hz.StallE;
    o_fd = hz.FlushD; o_fe = hz.FlushE; o_fm = hz.FlushM; o_busy = hz.BusyE;
    check_eq({tag, ".ForwardE"}, 32'(o_fwd), 32'(fwd));
    check_eq({tag, ".StallF"},   32'(o_sf),  32'(e_sf));
    check_eq({tag, ".StallD"},   32'(o_sd),  32'(ld || mcs));
    check_eq({tag, ".StallE"},   32'(o_se),  32'(mcs));
    check_eq({tag, ".FlushM"},   32'(o_fm),  32'(mcs));
    check_eq({tag, ".FlushD"},   32'(o_fd),  32'(e_fd));
    check_eq({tag, ".FlushE"},   32'(o_fe),  32'(e_fe));
    check_eq({tag, ".BusyE"},    32'(o_busy), 32'(m_busy));
`ifdef HAZARD_STATS_EN
    check_eq({tag, ".StallCount"}, 32'(hz.StallCount), 32'(m_stall_cnt));
    check_eq({tag, ".FlushCount"}, 32'(hz.FlushCount), 32'(m_flush_cnt));
`endif
    @(posedge clk);
    if (reset) begin
      m_busy = 1'b0; m_age = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      m_busy = mcs;
      m_age  = age_now;
`ifdef HAZARD_STATS_EN
      if (e_sf && m_stall_cnt < (2 ** STAT_WIDTH) - 1) m_stall_cnt++;
      if ((e_fd || e_fe) && m_flush_cnt < (2 ** STAT_WIDTH) - 1) m_flush_cnt++;
`endif
    end
    #1;
  endtask

  initial begin
    int n_stall;
    logic [NSRC-1:0] rm, rw;
    logic mc;
    reset = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    step("reset");
    reset = 1'b0;
    step("post_reset");
    check_eq("reset_all_zero", 32'({o_fwd, o_sf, o_sd, o_se, o_fd, o_fe, o_fm, o_busy}), 32'd0);

    // Forwarding priority
    drive(3'b001, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("fwd_mw");
    check_eq("fwd_prio_m", 32'(o_fwd), 32'(6'b000110));
    hz.RegWriteM = 1'b0;
    step("fwd_w");
    check_eq("fwd_prio_w", 32'(o_fwd), 32'(6'b000101));

    // Load-use
    drive('0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ldr");
    check_eq("ldr_signals", 32'({o_sf, o_sd, o_fe, o_se, o_fm}), 32'(5'b11100));
    idle_inputs();
    step("ldr_after");

    // Multi-cycle op of MUL_LATENCY cycles
    hz.MultiCycleE = 1'b1;
    n_stall = 0;
    for (int c = 1; c <= 4; c++) begin
      step("mc");
      check_eq($sformatf("mc_stall_c%0d", c), 32'({o_sf, o_sd, o_se, o_fm}), (c <= 3) ? 32'hF : 32'h0);
      check_eq($sformatf("mc_busy_c%0d", c), 32'(o_busy), (c >= 2) ? 32'd1 : 32'd0);
    end
    hz.MultiCycleE = 1'b0;
    step("mc_done");
    check_eq("mc_idle_c5", 32'(o_busy), 32'd0);

    // Branch during hold, then branch with FSM idle
    hz.MultiCycleE = 1'b1;
    step("br_hold1");
    hz.BranchTakenE = 1'b1;
    step("br_hold2");
    check_eq("br_hold_flush", 32'({o_fd, o_fe}), 32'(2'b10));
    hz.BranchTakenE = 1'b0;
    step("br_hold3");
    step("br_hold4");
    hz.MultiCycleE = 1'b0;
    hz.BranchTakenE = 1'b1;
    step("br_idle");
    check_eq("br_idle_flush", 32'({o_fd, o_fe}), 32'(2'b11));
    idle_inputs();

    // Reset mid-op, then a fresh op stalls the full MUL_LATENCY-1 cycles
    hz.MultiCycleE = 1'b1;
    step("rst_op1");
    reset = 1'b1;
    step("rst_op2");
    reset = 1'b0;
    hz.MultiCycleE = 1'b0;
    step("rst_after");
    check_eq("rst_mid_op", 32'({o_busy, o_sf, o_sd, o_se, o_fm}), 32'd0);
    hz.MultiCycleE = 1'b1;
    n_stall = 0;
    for (int c = 0; c < 4; c++) begin
      step("rst_fresh");
      n_stall += int'(o_se);
    end
    check_eq("rst_fresh_stalls", 32'(n_stall), 32'(MUL_LATENCY - 1));
    idle_inputs();
    step("rst_fresh_end");

`ifdef HAZARD_STATS_EN
    reset = 1'b1;
    step("stat_rst");
    reset = 1'b0;
    hz.PCWrPendingF = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step("stat");
      check_eq($sformatf("stat_stall_pre%0d", c), 32'(hz.StallCount), 32'((c < 3) ? c : 3));
    end
    idle_inputs();
    step("stat_end");
    check_eq("stat_flush_sat", 32'(hz.FlushCount), 32'd3);
`endif

    // Randomised traffic
    mc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rm = NSRC'($urandom);
      rw = NSRC'($urandom);
      if ($urandom_range(0, 5) == 0) mc = ~mc;
      drive(rm, rw, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 3) == 0), mc);
      reset = ($urandom_range(0, 63) == 0);
      step("rand");
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised successor of the pipeline hazard unit for the 5-stage ARM core (F/D/E/M/W).
- Generalises operand forwarding to NSRC source operands, covering register-shifted and MLA-style three-source operations.
- Adds a multi-cycle execute controller: an IDLE/BUSY FSM plus a down-counter that holds F/D/E and injects bubbles into M while a long-latency op (multiply/divide) occupies E.
- Keeps the existing load-use, branch and PC-write hazard handling.

Parameters:
- NSRC, 3, number of E-stage source operands needing forwarding (1..4)
- MUL_LATENCY, 4, cycles a multi-cycle op occupies E (1..16); 1 disables stalling
- CNT_WIDTH, 4, width of the internal latency counter; must satisfy 2^CNT_WIDTH >= MUL_LATENCY
- STAT_WIDTH, 16, width of the statistics counters (optional feature only)

Ports:
- clk  in  1  clock; one clock domain; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- Match_E_M  in  NSRC  source i of the E instruction matches the destination in M
- Match_E_W  in  NSRC  source i of the E instruction matches the destination in W
- Match_12D_E  in  1  a D source matches the E destination
- RegWriteM  in  1  M-stage instruction writes the register file
- RegWriteW  in  1  W-stage instruction writes the register file
- MemtoRegE  in  1  E-stage instruction is a load
- BranchTakenE  in  1  branch resolved taken in E
- PCWrPendingF  in  1  a PC write is in D/E/M
- PCSrcW  in  1  PC write retiring in W
- MultiCycleE  in  1  E holds a multi-cycle op (level; stays high while held)
- ForwardE  out  2*NSRC  per-source select, bits [2i+1:2i]: 10=ALUOutM, 01=ResultW, 00=register file
- StallF  out  1  hold the PC register
- StallD  out  1  hold the F/D register
- StallE  out  1  hold the D/E register
- FlushD  out  1  clear the F/D register
- FlushE  out  1  clear the D/E register
- FlushM  out  1  clear the E/M register (bubble)
- BusyE  out  1  FSM in BUSY

Behaviour:
- Forwarding is combinational, per source i:
  - 10 if Match_E_M[i] & RegWriteM;
  - else 01 if Match_E_W[i] & RegWriteW;
  - else 00.
  - M has priority over W.
- ldr_stall = Match_12D_E & MemtoRegE.
- FSM (registered state plus cnt[CNT_WIDTH-1:0]):
  - IDLE: if MultiCycleE and MUL_LATENCY>1, then mc_stall=1, next state BUSY, cnt<=MUL_LATENCY-2. Otherwise mc_stall=0.
  - BUSY, cnt!=0: mc_stall=1, cnt<=cnt-1.
  - BUSY, cnt==0: mc_stall=0, next state IDLE; the op leaves E this cycle.
  - Result: the op occupies E for exactly MUL_LATENCY cycles, of which MUL_LATENCY-1 are stalled.
- MultiCycleE deasserting while in BUSY (op squashed) forces IDLE and cnt<=0 on the next edge; mc_stall=0 in that cycle.
- Output equations:
  - StallF = ldr_stall | PCWrPendingF | mc_stall
  - StallD = ldr_stall | mc_stall
  - StallE = mc_stall
  - FlushM = mc_stall
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenE
  - FlushE = (ldr_stall | BranchTakenE) & ~mc_stall
- Precedence: mc_stall overrides FlushE, so a held E instruction is never cleared. FlushD may coincide with StallD; flush wins at the register.
- BusyE = (state==BUSY).
- Reset: state IDLE, cnt 0 (and statistics counters 0) on the next edge, including mid-operation.
- Reset values of outputs: no registered outputs; all outputs are functions of state and inputs. With inputs low after reset, every output is 0 and ForwardE is all-zero.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds two outputs:
  - StallCount (STAT_WIDTH): increments each cycle StallF=1.
  - FlushCount (STAT_WIDTH): increments each cycle FlushD|FlushE=1.
  - Both saturate at all-ones, never wrap, and clear on reset.
- When undefined, the ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Forwarding priority: Match_E_M=3'b001, Match_E_W=3'b011, RegWriteM=1, RegWriteW=1 -> ForwardE=6'b000110. Same stimulus with RegWriteM=0 -> ForwardE=6'b000101.
- Load-use: Match_12D_E=1, MemtoRegE=1 for one cycle -> StallF=StallD=FlushE=1, StallE=0, FlushM=0 in that cycle.
- Multi-cycle, MUL_LATENCY=4: MultiCycleE high for 4 cycles -> StallF/D/E and FlushM high in cycles 1-3, low in cycle 4; BusyE high in cycles 2-4; state IDLE in cycle 5.
- Branch during hold: BranchTakenE=1 while mc_stall=1 -> FlushD=1, FlushE=0. BranchTakenE=1 with FSM idle -> FlushD=FlushE=1.
- Reset mid-op: assert reset in cycle 2 of a 4-cycle op -> next cycle BusyE=0 and all stalls 0 with MultiCycleE low. A fresh MultiCycleE then stalls for the full 3 cycles.
- HAZARD_STATS_EN, STAT_WIDTH=2: hold PCWrPendingF=1 for 5 cycles -> StallCount reads 1,2,3,3,3; FlushCount reaches 3 and holds.
